// File: rtl/qsram_ctrl_pkg.sv
// Shared types and configuration checks for the QSRAM access controller.
package qsram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        REFR = 2'd3
    } state_e;

    localparam int unsigned STATE_W          = 2;
    localparam int unsigned READ_LATENCY_MIN = 1;
    localparam int unsigned READ_LATENCY_MAX = 7;

    function automatic bit cfg_ok(input int unsigned read_latency,
                                  input int unsigned refresh_period,
                                  input int unsigned refresh_cycles);
        return (read_latency >= READ_LATENCY_MIN) && (read_latency <= READ_LATENCY_MAX) &&
               (refresh_cycles >= 1) &&
               (refresh_period >= refresh_cycles + read_latency + 2);
    endfunction

endpackage

// File: rtl/qsram_refresh_timer.sv
// Free-running refresh interval counter with a sticky pending flag.
module qsram_refresh_timer #(
    parameter int unsigned PERIOD = 780
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic pending_o,
    output logic pending_next_o
);

    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          wrap;

    // A wrap coinciding with clear starts a fresh interval, so set wins.
    always_comb begin
        wrap   = (cnt_q == LAST);
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        pend_d = wrap | (pend_q & ~clear_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign pending_o      = pend_q;
    assign pending_next_o = pend_d;

endmodule

// File: rtl/qsram_access_controller.sv
// Single-word request sequencer for the SDR QSRAM; all outputs registered.
// Refresh support is built only when QSRAM_CTRL_REFRESH_EN is defined.
module qsram_access_controller
    import qsram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 33,
    parameter int unsigned DATA_WIDTH     = 9,
    parameter int unsigned READ_LATENCY   = 2,
    parameter int unsigned REFRESH_PERIOD = 780,
    parameter int unsigned REFRESH_CYCLES = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [ADDR_WIDTH-1:0] ReqAddr,
    input  logic [DATA_WIDTH-1:0] ReqWdata,
    output logic                  RspValid,
    output logic [DATA_WIDTH-1:0] RspRdata,
    output logic [ADDR_WIDTH-1:0] MemAddress,
    output logic                  MemEnable,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic                  MemRefresh,
    output logic [DATA_WIDTH-1:0] MemDataOut,
    output logic                  MemDataOe,
    input  logic [DATA_WIDTH-1:0] MemDataIn
);

    localparam bit CFG_OK = cfg_ok(READ_LATENCY, REFRESH_PERIOD, REFRESH_CYCLES);
    if (!CFG_OK) begin : g_cfg_err
        $error("qsram_access_controller: parameter out of range");
    end

    localparam logic [2:0] RD_LAST = 3'(READ_LATENCY - 1);

    state_e                state_q, state_d;
    logic [2:0]            rd_cnt_q, rd_cnt_d;
    logic                  ready_q, rsp_valid_q, en_q, rd_q, wr_q, refr_q, oe_q;
    logic [DATA_WIDTH-1:0] rdata_q, wdata_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  pend_q, pend_next, refr_last, accept, rd_last;

`ifdef QSRAM_CTRL_REFRESH_EN
    localparam int unsigned RCW = $clog2(REFRESH_CYCLES + 1);
    localparam logic [RCW-1:0] REF_LAST = RCW'(REFRESH_CYCLES - 1);

    logic [RCW-1:0] ref_cnt_q, ref_cnt_d;

    always_comb begin
        ref_cnt_d = (state_q == REFR) ? ref_cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge Clock) begin
        if (Reset) ref_cnt_q <= '0;
        else       ref_cnt_q <= ref_cnt_d;
    end

    assign refr_last = (ref_cnt_q == REF_LAST);

    qsram_refresh_timer #(
        .PERIOD (REFRESH_PERIOD)
    ) u_refresh_timer (
        .clk_i          (Clock),
        .rst_i          (Reset),
        .clear_i        ((state_q == REFR) && refr_last),
        .pending_o      (pend_q),
        .pending_next_o (pend_next)
    );
`else
    assign refr_last = 1'b1;
    assign pend_q    = 1'b0;
    assign pend_next = 1'b0;
`endif

    assign accept  = ReqValid && ready_q && (state_q == IDLE) && !pend_q;
    assign rd_last = (state_q == RD) && (rd_cnt_q == RD_LAST);

    // A refresh that came due during a read starts right after it, skipping IDLE.
    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        unique case (state_q)
            IDLE: begin
                rd_cnt_d = '0;
                if (pend_q)      state_d = REFR;
                else if (accept) state_d = ReqWrite ? WR : RD;
            end
            WR:   state_d = IDLE;
            RD: begin
                if (rd_cnt_q == RD_LAST) state_d = pend_q ? REFR : IDLE;
                else                     rd_cnt_d = rd_cnt_q + 1'b1;
            end
            REFR: if (refr_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            rd_cnt_q    <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            en_q        <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            refr_q      <= 1'b0;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            ready_q     <= (state_d == IDLE) && !pend_next;
            en_q        <= (state_d != IDLE);
            rd_q        <= (state_d == RD);
            wr_q        <= (state_d == WR);
            refr_q      <= (state_d == REFR);
            oe_q        <= (state_d == WR);
            rsp_valid_q <= rd_last;
            if (rd_last) rdata_q <= MemDataIn;
            if (accept) begin
                addr_q <= ReqAddr;
                if (ReqWrite) wdata_q <= ReqWdata;
            end
        end
    end

    assign ReqReady   = ready_q;
    assign RspValid   = rsp_valid_q;
    assign RspRdata   = rdata_q;
    assign MemAddress = addr_q;
    assign MemEnable  = en_q;
    assign MemRead    = rd_q;
    assign MemWrite   = wr_q;
    assign MemDataOut = wdata_q;
    assign MemDataOe  = oe_q;
`ifdef QSRAM_CTRL_REFRESH_EN
    assign MemRefresh = refr_q;
`else
    assign MemRefresh = 1'b0;
`endif

endmodule

// File: tb/tb_qsram_access_controller.sv
// Scoreboard bench for qsram_access_controller; refresh scenarios run when
// QSRAM_CTRL_REFRESH_EN is defined.
module tb_qsram_access_controller;

    localparam int AW = 33;
    localparam int DW = 9;
    localparam int RL = 2;
    localparam int RP = 16;
    localparam int RC = 4;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          ReqValid = 1'b0;
    logic          ReqWrite = 1'b0;
    logic [AW-1:0] ReqAddr = '0;
    logic [DW-1:0] ReqWdata = '0;
    logic [DW-1:0] MemDataIn = '0;
    logic          ReqReady, RspValid, MemEnable, MemRead, MemWrite, MemRefresh, MemDataOe;
    logic [DW-1:0] RspRdata, MemDataOut;
    logic [AW-1:0] MemAddress;

    qsram_access_controller #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .READ_LATENCY   (RL),
        .REFRESH_PERIOD (RP),
        .REFRESH_CYCLES (RC)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .ReqValid   (ReqValid),
        .ReqReady   (ReqReady),
        .ReqWrite   (ReqWrite),
        .ReqAddr    (ReqAddr),
        .ReqWdata   (ReqWdata),
        .RspValid   (RspValid),
        .RspRdata   (RspRdata),
        .MemAddress (MemAddress),
        .MemEnable  (MemEnable),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemRefresh (MemRefresh),
        .MemDataOut (MemDataOut),
        .MemDataOe  (MemDataOe),
        .MemDataIn  (MemDataIn)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t wq[$];
    exp_t rq[$];
    exp_t e;

    function automatic logic [DW-1:0] rdmodel(input logic [AW-1:0] a);
        return a[DW-1:0] ^ 9'h0C6;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // SRAM model: data is valid in the RL-th consecutive cycle of MemRead.
    int rdcnt = 0;
    always @(negedge Clock) begin
        if (MemRead) rdcnt = rdcnt + 1;
        else         rdcnt = 0;
        MemDataIn = (rdcnt == RL) ? rdmodel(MemAddress) : 9'h1FF;
    end

    bit prev_read = 1'b0;
    bit prev_refr = 1'b0;
    int refresh_seen = 0;
    int last_rise = -1;

    always @(negedge Clock) begin
        if (MemRead && rq.size() > 0) begin
            chk("rd_addr", MemAddress, rq[0].addr);
            chk("rd_enable", MemEnable, 1);
        end
        if (RspValid) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got RspValid=1 data 0x%0h expected none (cycle %0d)",
                         RspRdata, cyc);
            end else begin
                e = rq.pop_front();
                chk("rsp_data", RspRdata, e.data);
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
        if (MemWrite) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got MemWrite=1 expected none (cycle %0d)", cyc);
            end else begin
                e = wq.pop_front();
                chk("wr_addr", MemAddress, e.addr);
                chk("wr_data", MemDataOut, e.data);
                chk("wr_oe", MemDataOe, 1);
                chk("wr_enable", MemEnable, 1);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
        if (MemRefresh) begin
            refresh_seen++;
            if (!prev_refr) last_rise = cyc;
        end
        checks++;
        if ((int'(MemRead) + int'(MemWrite) + int'(MemRefresh) > 1) ||
            (MemDataOe && !MemWrite) || (MemDataOe && prev_read)) begin
            errors++;
            $display("FAIL pin_exclusive: got rd=%0b wr=%0b refr=%0b oe=%0b prev_rd=%0b expected exclusive",
                     MemRead, MemWrite, MemRefresh, MemDataOe, prev_read);
        end
        prev_read = MemRead;
        prev_refr = MemRefresh;
    end

    task automatic req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, output int acc);
        @(posedge Clock);
        #1;
        ReqValid = 1'b1;
        ReqWrite = wr;
        ReqAddr  = a;
        ReqWdata = d;
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clock);
            if (ReqReady) begin
                @(posedge Clock);
                #1;
                acc = cyc;
                break;
            end
        end
        ReqValid = 1'b0;
        chk("req_accepted", (acc >= 0), 1);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clock);
            if (rq.size() == 0 && wq.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain", done, 1);
    endtask

`ifdef QSRAM_CTRL_REFRESH_EN
    task automatic sync_refresh(output int rise, output int fall);
        int hi = 0;
        rise = -1;
        fall = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge Clock);
            if (MemRefresh) begin
                rise = cyc;
                break;
            end
        end
        if (rise >= 0) begin
            hi = 1;
            for (int i = 0; i < 16; i++) begin
                @(negedge Clock);
                if (!MemRefresh) begin
                    fall = cyc;
                    break;
                end
                hi++;
            end
        end
        chk("refresh_found", (rise >= 0 && fall >= 0), 1);
        chk("refresh_len", hi, RC);
    endtask
`endif

    task automatic resync();
`ifdef QSRAM_CTRL_REFRESH_EN
        int r, f;
        sync_refresh(r, f);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int acc, a1, a2;
`ifdef QSRAM_CTRL_REFRESH_EN
        int r1, f1, r2, f2, r3;
`endif
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        chk("rst_ready", ReqReady, 0);
        chk("rst_rspvalid", RspValid, 0);
        chk("rst_rdata", RspRdata, 0);
        chk("rst_addr", MemAddress, 0);
        chk("rst_pins", {MemEnable, MemRead, MemWrite, MemRefresh, MemDataOe}, 0);
        chk("rst_dout", MemDataOut, 0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;

        // 1: single write
        req(1'b1, 33'h1_0000_0005, 9'h1A5, acc);
        wq.push_back('{33'h1_0000_0005, 9'h1A5, acc});
        @(negedge Clock);
        chk("t1_ready_low", ReqReady, 0);
        @(negedge Clock);
        chk("t1_ready_back", ReqReady, 1);
        drain();

        // 2: single read, then RspRdata must hold
        resync();
        req(1'b0, 33'h0_0000_0005, 9'h000, acc);
        rq.push_back('{33'h0_0000_0005, 9'h0C3, acc + RL});
        drain();
        repeat (3) @(negedge Clock);
        chk("t2_hold", RspRdata, 9'h0C3);

        // 3: back-to-back write then read
        resync();
        req(1'b1, 33'h0_ABCD_0123, 9'h05A, a1);
        wq.push_back('{33'h0_ABCD_0123, 9'h05A, a1});
        req(1'b0, 33'h1_2345_6789, 9'h000, a2);
        rq.push_back('{33'h1_2345_6789, rdmodel(33'h1_2345_6789), a2 + RL});
        chk("t3_gap", a2 - a1, 2);
        drain();

`ifdef QSRAM_CTRL_REFRESH_EN
        // 4: idle refresh period and stall during refresh
        sync_refresh(r1, f1);
        sync_refresh(r2, f2);
        chk("t4_period", r2 - r1, RP);
        r3 = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (MemRefresh) begin
                r3 = cyc;
                break;
            end
        end
        chk("t4_rise_found", (r3 >= 0), 1);
        ReqValid = 1'b1;
        ReqWrite = 1'b0;
        ReqAddr  = 33'h0_0000_0042;
        acc = -1;
        for (int i = 0; i < 20; i++) begin
            if (MemRefresh) chk("t4_stall_ready", ReqReady, 0);
            else if (ReqReady) begin
                @(posedge Clock);
                #1;
                acc = cyc;
                break;
            end
            @(negedge Clock);
        end
        ReqValid = 1'b0;
        chk("t4_accept_cycle", acc, r3 + 5);
        rq.push_back('{33'h0_0000_0042, rdmodel(33'h0_0000_0042), acc + RL});
        drain();

        // 5: refresh comes due mid-read; queued write waits behind it
        sync_refresh(r1, f1);
        while (cyc < f1 + 8) @(negedge Clock);
        req(1'b0, 33'h1_FFFF_FF10, 9'h000, acc);
        chk("t5_read_accept", acc, f1 + 10);
        rq.push_back('{33'h1_FFFF_FF10, rdmodel(33'h1_FFFF_FF10), acc + RL});
        req(1'b1, 33'h0_0000_0300, 9'h133, a1);
        wq.push_back('{33'h0_0000_0300, 9'h133, a1});
        chk("t5_refr_follows", last_rise, acc + RL);
        chk("t5_write_accept", a1, acc + 7);
        drain();
        resync();
`endif

        // 6: reset in second read cycle abandons the access
        req(1'b0, 33'h0_0000_0077, 9'h000, acc);
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(negedge Clock);
        chk("t6_rd2", MemRead, 1);
        @(posedge Clock);
        #1;
        @(negedge Clock);
        chk("t6_rspvalid", RspValid, 0);
        chk("t6_rdata", RspRdata, 0);
        chk("t6_pins", {MemEnable, MemRead, MemWrite, MemRefresh, MemDataOe}, 0);
        chk("t6_addr", MemAddress, 0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        repeat (6) @(negedge Clock);
        chk("t6_ready_after", ReqReady, 1);

`ifdef QSRAM_CTRL_REFRESH_EN
        chk("refresh_seen", (refresh_seen > 0), 1);
`else
        chk("no_refresh", refresh_seen, 0);
`endif
        chk("rq_empty", rq.size(), 0);
        chk("wq_empty", wq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
